// File: rtl/display_source_sched_pkg.sv
// Shared types and constants for the display source scheduler.
package display_source_sched_pkg;
    localparam int RGB_W = 24;
    localparam int LED_W = 6;
    localparam logic [RGB_W-1:0] RGB_BLACK = '0;

    typedef enum logic [1:0] {
        ST_SHOW  = 2'd0,
        ST_PEND  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;
endpackage

// File: rtl/display_source_sched_sync_debounce.sv
// Two-flop synchroniser followed by a stability filter: q follows d_async only
// after DEBOUNCE_CYCLES consecutive equal synchronised samples.
module display_source_sched_sync_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic clear,
    input  logic d_async,
    output logic q
);
    logic        s1, s2, cand;
    logic [15:0] remain;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cand   <= 1'b0;
            remain <= '0;
            q      <= 1'b0;
        end else begin
            s1 <= d_async;
            s2 <= s1;
            // the changing sample counts as the first of the stable run
            if (s2 != cand) begin
                cand   <= s2;
                remain <= DEBOUNCE_CYCLES - 16'd1;
                if (DEBOUNCE_CYCLES == 16'd1) q <= s2;
            end else if (remain != 16'd0) begin
                remain <= remain - 16'd1;
                if (remain == 16'd1) q <= cand;
            end
        end
    end
endmodule

// File: rtl/display_source_sched.sv
// Frame-synchronous source scheduler between the bit generators and the VGA pads.
//  state    | meaning
//  ST_SHOW  | active source displayed, waiting for a target change
//  ST_PEND  | target differs, waiting for the next frame tick
//  ST_BLANK | black frames across the switch, active_src flips on exit
module display_source_sched
    import display_source_sched_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [3:0]  BLANK_FRAMES    = 4'd2,
    parameter logic [7:0]  AUTO_FRAMES     = 8'd120
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             pixel_en,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             bright_in,
    input  logic [RGB_W-1:0] rgb1,
    input  logic [RGB_W-1:0] rgb2,
    input  logic [LED_W-1:0] leds_in,
    input  logic             sel_req,
    input  logic             auto_mode,
    output logic [RGB_W-1:0] rgb_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic             blank_n_out,
    output logic [LED_W-1:0] leds_out,
    output logic             active_src,
    output logic             switching
);
    state_t     state;
    logic       target;
    logic       sel_db;
    logic [3:0] blank_left;
    logic [7:0] auto_left;
    logic       frame_tick;

    display_source_sched_sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sel_db (
        .clk    (clk),
        .clear  (clear),
        .d_async(sel_req),
        .q      (sel_db)
    );

    // vs_out doubles as the registered vsync for falling-edge detection
    assign frame_tick = pixel_en & vs_out & ~vsync_in;
    assign switching  = (state != ST_SHOW);
    assign leds_out   = (active_src && state == ST_SHOW) ? leds_in : '0;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state       <= ST_SHOW;
            active_src  <= 1'b0;
            target      <= 1'b0;
            blank_left  <= '0;
            auto_left   <= AUTO_FRAMES - 8'd1;
            rgb_out     <= RGB_BLACK;
            hs_out      <= 1'b1;
            vs_out      <= 1'b1;
            blank_n_out <= 1'b0;
        end else begin
            if (!auto_mode) begin
                target    <= sel_db;
                auto_left <= AUTO_FRAMES - 8'd1;
            end else if (frame_tick && state == ST_SHOW) begin
                if (auto_left == 8'd0) begin
                    auto_left <= AUTO_FRAMES - 8'd1;
                    target    <= ~active_src;
                end else begin
                    auto_left <= auto_left - 8'd1;
                end
            end

            case (state)
                ST_SHOW: begin
                    if (target != active_src) state <= ST_PEND;
                end
                ST_PEND: begin
                    if (target == active_src) begin
                        state <= ST_SHOW;
                    end else if (frame_tick) begin
                        state      <= ST_BLANK;
                        blank_left <= BLANK_FRAMES - 4'd1;
                    end
                end
                ST_BLANK: begin
                    if (frame_tick) begin
                        if (blank_left == 4'd0) begin
                            active_src <= ~active_src;
                            state      <= ST_SHOW;
                        end else begin
                            blank_left <= blank_left - 4'd1;
                        end
                    end
                end
                default: state <= ST_SHOW;
            endcase

            if (pixel_en) begin
                rgb_out     <= (bright_in && state != ST_BLANK) ?
                               (active_src ? rgb2 : rgb1) : RGB_BLACK;
                hs_out      <= hsync_in;
                vs_out      <= vsync_in;
                blank_n_out <= bright_in;
            end
        end
    end
endmodule
